// File: rtl/node_reporter_pkg.sv
// node_reporter shared definitions: frame bytes, line classes, FSM states.
// Frame length depends on NODE_REPORTER_CHECKSUM_EN (4 bytes when defined, 3 otherwise).
package node_reporter_pkg;

  localparam logic [7:0] HEADER = 8'hA5;
  localparam logic [7:0] CODE_L = 8'h4C;
  localparam logic [7:0] CODE_R = 8'h52;

`ifdef NODE_REPORTER_CHECKSUM_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 3;
`endif

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_L    = 2'd1,
    CLS_R    = 2'd2
  } cls_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Raw line pattern -> node class (left/right branch or nothing).
  function automatic cls_t classify(input logic [2:0] ls);
    case (ls)
      3'b110:  return CLS_L;
      3'b011:  return CLS_R;
      default: return CLS_NONE;
    endcase
  endfunction

  // Side bit (0 = left, 1 = right) -> ASCII side code.
  function automatic logic [7:0] side_code(input logic side);
    return side ? CODE_R : CODE_L;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser, LSB first, idle high. Each bit lasts CLK_DIV cycles.
// done is high during the final cycle of the stop bit so the caller can
// issue the next start with exactly one idle cycle in between.
module uart_tx_byte #(
  parameter int CLK_DIV = 5208
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic        active;
  logic [3:0]  bit_idx;
  logic [15:0] div;
  logic [8:0]  shreg;

  assign done = active && (div == LAST) && (bit_idx == 4'd9);

  // Bit timer and shifter; tx is registered so it is glitch-free.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tx      <= 1'b1;
      active  <= 1'b0;
      bit_idx <= '0;
      div     <= '0;
      shreg   <= '1;
    end else if (start && !active) begin
      tx      <= 1'b0;
      active  <= 1'b1;
      bit_idx <= '0;
      div     <= '0;
      shreg   <= {1'b1, data};
    end else if (active) begin
      if (div == LAST) begin
        div <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        div <= div + 16'd1;
      end
    end
  end

endmodule

// File: rtl/node_reporter.sv
// Line-follower node reporter: debounces line_state, counts node events and
// sends a framed report over UART to the XBee. One pending frame is buffered;
// further events while it is full are counted but dropped (sticky overflow).
// Optional checksum byte: define NODE_REPORTER_CHECKSUM_EN.
import node_reporter_pkg::*;

module node_reporter #(
  parameter int CLK_DIV  = 5208,
  parameter int DEBOUNCE = 16
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic [2:0] line_state,
  output logic       xbee_tx,
  output logic       busy,
  output logic [7:0] node_count,
  output logic       overflow
);

  logic [1:0] rst_pipe;
  logic       rst_s;

  // Reset asserts asynchronously, releases after two clock edges.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_s = rst_pipe[1];

  // ---------------- debounce / event detect ----------------
  cls_t       cls, last_cls, deb;
  logic [7:0] run_cnt, run_nxt;
  logic       accept, evt, evt_side;

  // Length of the current run of identical raw classes, including this cycle.
  always_comb begin
    cls = classify(line_state);
    if (cls == last_cls) run_nxt = (run_cnt == 8'hFF) ? run_cnt : run_cnt + 8'd1;
    else                 run_nxt = 8'd1;
    accept   = (run_nxt >= 8'(DEBOUNCE));
    evt      = rst_s && accept && (deb == CLS_NONE) && (cls != CLS_NONE);
    evt_side = (cls == CLS_R);
  end

  // Run tracking and debounced class register.
  always_ff @(posedge clock or negedge rst_s) begin
    if (!rst_s) begin
      last_cls <= CLS_NONE;
      run_cnt  <= '0;
      deb      <= CLS_NONE;
    end else begin
      last_cls <= cls;
      run_cnt  <= run_nxt;
      if (accept) deb <= cls;
    end
  end

  // ---------------- frame FSM ----------------
  state_t     state, state_nxt;
  logic [1:0] byte_idx;
  logic       last_byte, pop, start, done;
  logic [7:0] tx_data;
  logic       cur_side, pend_side, pend_vld;
  logic [7:0] cur_cnt, pend_cnt;
  logic       idle_like;

  assign last_byte = (byte_idx == 2'(FRAME_LEN - 1));
  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);

  // Next state; LOAD and WAIT are the idle-high gap cycles that launch a byte.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pop       = 1'b0;
    case (state)
      ST_IDLE: if (evt) state_nxt = ST_LOAD;
      ST_LOAD: begin
        start     = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: if (done) begin
        if (!last_byte) state_nxt = ST_WAIT;
        else if (pend_vld) begin
          state_nxt = ST_LOAD;
          pop       = 1'b1;
        end else state_nxt = ST_DONE;
      end
      ST_WAIT: begin
        start     = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_DONE: state_nxt = evt ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst_s) begin
    if (!rst_s) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Byte index within the frame; restarts whenever a frame is loaded.
  always_ff @(posedge clock or negedge rst_s) begin
    if (!rst_s)                                   byte_idx <= '0;
    else if (state_nxt == ST_LOAD)                byte_idx <= '0;
    else if (state == ST_SEND && done && !last_byte) byte_idx <= byte_idx + 2'd1;
  end

  // Byte to send for the current frame.
  always_comb begin
    tx_data = HEADER;
    case (byte_idx)
      2'd1:    tx_data = side_code(cur_side);
      2'd2:    tx_data = cur_cnt;
`ifdef NODE_REPORTER_CHECKSUM_EN
      2'd3:    tx_data = HEADER ^ side_code(cur_side) ^ cur_cnt;
`endif
      default: tx_data = HEADER;
    endcase
  end

  // Event counting, current frame and single pending slot.
  // An event in the cycle the slot is popped refills it without a drop.
  always_ff @(posedge clock or negedge rst_s) begin
    if (!rst_s) begin
      node_count <= '0;
      overflow   <= 1'b0;
      cur_side   <= 1'b0;
      cur_cnt    <= '0;
      pend_vld   <= 1'b0;
      pend_side  <= 1'b0;
      pend_cnt   <= '0;
    end else begin
      if (evt) node_count <= node_count + 8'd1;
      if (pop) begin
        cur_side <= pend_side;
        cur_cnt  <= pend_cnt;
      end
      if (evt && idle_like) begin
        cur_side <= evt_side;
        cur_cnt  <= node_count + 8'd1;
      end else if (evt && (pop || !pend_vld)) begin
        pend_vld  <= 1'b1;
        pend_side <= evt_side;
        pend_cnt  <= node_count + 8'd1;
      end else begin
        if (evt) overflow <= 1'b1;
        if (pop) pend_vld <= 1'b0;
      end
    end
  end

  assign busy = ((state != ST_IDLE) && (state != ST_DONE)) || pend_vld || evt;

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clock (clock),
    .rst_n (rst_s),
    .start (start),
    .data  (tx_data),
    .tx    (xbee_tx),
    .done  (done)
  );

endmodule

// File: tb/tb_node_reporter.sv
// Directed bench for node_reporter (CLK_DIV=4, DEBOUNCE=3). xbee_tx and busy
// are recorded every falling edge; frames are decoded from that record.
module tb_node_reporter;

  logic       clock = 1'b0;
  logic       rst_n;
  logic [2:0] line_state;
  logic       xbee_tx, busy, overflow;
  logic [7:0] node_count;

  int vec  = 0;
  int miss = 0;

`ifdef NODE_REPORTER_CHECKSUM_EN
  localparam int          NB = 4;
  localparam logic [31:0] F_L1 = 32'hE8014CA5;
  localparam logic [31:0] F_R2 = 32'hF50252A5;
  localparam logic [31:0] F_R0 = 32'hF70052A5;
`else
  localparam int          NB = 3;
  localparam logic [31:0] F_L1 = 32'h00014CA5;
  localparam logic [31:0] F_R2 = 32'h000252A5;
  localparam logic [31:0] F_R0 = 32'h000052A5;
`endif
  localparam int BYTE_T = 41;  // 10 bits * 4 cycles + 1 idle cycle
  localparam int DEPTH  = 8192;

  node_reporter #(.CLK_DIV(4), .DEBOUNCE(3)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .line_state (line_state),
    .xbee_tx    (xbee_tx),
    .busy       (busy),
    .node_count (node_count),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  logic trace  [0:DEPTH-1];
  logic btrace [0:DEPTH-1];
  int   cyc = 0;

  always @(negedge clock) begin
    if (cyc < DEPTH) begin
      trace[cyc]  <= xbee_tx;
      btrace[cyc] <= busy;
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int zeros(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (trace[i] !== 1'b1) n++;
    return n;
  endfunction

  // Decode an NB-byte frame whose first start bit begins at cycle t0.
  task automatic decode_frame(input string tag, input int t0, input logic [31:0] exp);
    logic [31:0] fr = '0;
    int bad;
    chk({tag, "_pre_idle"}, 32'(trace[t0-1]), 32'd1);
    for (int b = 0; b < NB; b++) begin
      int base = t0 + b * BYTE_T;
      bad = 0;
      for (int i = 0; i < 10; i++)
        for (int j = 1; j < 4; j++)
          if (trace[base+4*i+j] !== trace[base+4*i]) bad++;
      chk({tag, "_bit_hold"}, 32'(bad), 32'd0);
      chk({tag, "_start_stop"}, {30'd0, trace[base], trace[base+36]}, 32'd1);
      for (int i = 0; i < 8; i++) fr[8*b+i] = trace[base+4+4*i];
      chk({tag, "_gap"}, 32'(trace[base+40]), 32'd1);
    end
    chk({tag, "_data"}, fr, exp);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    line_state = 3'b010;
    step(3);
    chk("rst_tx",   32'(xbee_tx),    32'd1);
    chk("rst_busy", 32'(busy),       32'd0);
    chk("rst_cnt",  32'(node_count), 32'd0);
    chk("rst_ovf",  32'(overflow),   32'd0);
    rst_n = 1'b1;
    step(4);
  endtask

  initial begin
    int n0, t0, r0;
    rst_n      = 1'b0;
    line_state = 3'b010;
    do_reset();

    // Right pattern held only 2 cycles: no event.
    n0 = cyc;
    line_state = 3'b011;
    step(2);
    line_state = 3'b010;
    step(60);
    chk("short_no_tx",  32'(zeros(n0, n0 + 59)), 32'd0);
    chk("short_no_cnt", 32'(node_count),         32'd0);

    // Left node: event on 3rd held cycle, start bit 2 cycles later.
    n0 = cyc;
    line_state = 3'b110;
    step(4 + NB * BYTE_T + 5);
    t0 = n0 + 4;
    chk("l_busy_before", 32'(btrace[n0+1]), 32'd0);
    chk("l_busy_evt",    32'(btrace[n0+2]), 32'd1);
    chk("l_start_lat",   32'(trace[t0]),    32'd0);
    decode_frame("l1", t0, F_L1);
    chk("l_busy_stop",   32'(btrace[t0 + NB*BYTE_T - 2]), 32'd1);
    chk("l_busy_low",    32'(btrace[t0 + NB*BYTE_T - 1]), 32'd0);
    chk("l_cnt",         32'(node_count), 32'd1);
    line_state = 3'b010;
    step(5);

    // Three events in one frame: second queued, third dropped.
    do_reset();
    n0 = cyc;
    for (int e = 0; e < 3; e++) begin
      line_state = (e == 1) ? 3'b011 : 3'b110;
      step(3);
      line_state = 3'b010;
      step(3);
    end
    step(2 * NB * BYTE_T + 70);
    t0 = n0 + 4;
    decode_frame("q1", t0, F_L1);
    decode_frame("q2", t0 + NB * BYTE_T, F_R2);
    chk("q_no_third", 32'(zeros(t0 + 2*NB*BYTE_T, t0 + 2*NB*BYTE_T + 60)), 32'd0);
    chk("q_cnt", 32'(node_count), 32'd3);
    chk("q_ovf", 32'(overflow),   32'd1);

    // Count wrap: 255 events, then a right node reports count 0.
    do_reset();
    for (int e = 0; e < 255; e++) begin
      line_state = 3'b110;
      step(3);
      line_state = 3'b010;
      step(3);
    end
    chk("w_cnt255", 32'(node_count), 32'd255);
    for (int k = 0; k < 1000 && busy; k++) step(1);
    chk("w_drain", 32'(busy), 32'd0);
    n0 = cyc;
    line_state = 3'b011;
    step(4 + NB * BYTE_T + 5);
    decode_frame("w", n0 + 4, F_R0);
    chk("w_cnt0", 32'(node_count), 32'd0);
    line_state = 3'b010;
    step(5);

    // Reset during the start bit of byte1 aborts the frame.
    do_reset();
    n0 = cyc;
    line_state = 3'b110;
    step(46);
    chk("a_pre_abort", 32'(xbee_tx), 32'd0);
    line_state = 3'b010;
    rst_n = 1'b0;
    #1;
    chk("a_tx",   32'(xbee_tx),    32'd1);
    chk("a_busy", 32'(busy),       32'd0);
    chk("a_cnt",  32'(node_count), 32'd0);
    chk("a_ovf",  32'(overflow),   32'd0);
    step(3);
    rst_n = 1'b1;
    r0 = cyc;
    step(150);
    chk("a_quiet",   32'(zeros(r0, r0 + 140)), 32'd0);
    chk("a_cnt_end", 32'(node_count),          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/node_reporter.md
NODE_REPORTER -- requirements
Module: node_reporter

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter DEBOUNCE, default 16, consecutive cycles a sensor pattern must hold before it is accepted; legal range 1..255.
REQ-003 SHALL have port clock, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port line_state, input, 3, thresholded line bits from the line follower: [2]=left, [1]=centre, [0]=right; 1 means the line is detected.
REQ-006 SHALL have port xbee_tx, output, 1, UART 8N1 serial line to the XBee, LSB first, idle high.
REQ-007 SHALL have port busy, output, 1, high while a frame is being transmitted or one is pending.
REQ-008 SHALL have port node_count, output, 8, count of accepted node events.
REQ-009 SHALL have port overflow, output, 1, sticky flag set when an event is dropped.

Function
REQ-010 SHALL classify line_state every cycle: 3'b110 = NODE_L, 3'b011 = NODE_R, any other value = NONE.
REQ-011 SHALL update the debounced class only after the raw class is unchanged for DEBOUNCE consecutive cycles; any change in the raw class restarts the count.
REQ-012 SHALL raise a one-cycle internal event when the debounced class moves from NONE to NODE_L or NODE_R; NODE_L<->NODE_R and X->NONE transitions SHALL NOT raise an event.
REQ-013 SHALL increment node_count in the event cycle; 255 wraps to 0.
REQ-014 SHALL build the frame: byte0 0xA5, byte1 side code (0x4C for L, 0x52 for R), byte2 node_count after the increment, and byte3 checksum when enabled (see REQ-026).
REQ-015 SHALL use a top-level FSM with states IDLE -> LOAD -> SEND -> WAIT -> (SEND for the next byte | DONE) -> IDLE, or -> LOAD if an event is pending.
REQ-016 SHALL drive the falling edge of the first start bit exactly 2 cycles after the event cycle when idle.
REQ-017 SHALL hold each bit (start, 8 data, stop) for exactly CLK_DIV cycles; exactly 1 idle-high cycle SHALL separate consecutive bytes and consecutive frames.
REQ-018 SHALL latch an event that arrives while a frame is in flight into a single pending slot (side and count); the pending frame SHALL be sent after the current one.
REQ-019 SHALL drop an event that arrives while the pending slot is full, still count it in node_count, and set overflow.
REQ-020 SHALL handle an event in the same cycle that the pending slot is emptied into LOAD by placing it in the slot with no drop.
REQ-021 SHALL assert busy from the event cycle until the last stop bit of the final queued frame completes.

Reset
REQ-022 SHALL force, while rst_n is low: xbee_tx=1, busy=0, node_count=0, overflow=0, FSM=IDLE, debounced class=NONE, pending slot empty, all counters 0.
REQ-023 SHALL abort any frame when reset is asserted mid-frame, with xbee_tx high immediately (asynchronously) and no resumption after release.
REQ-024 SHALL release reset synchronously through a 2-flop synchroniser on the deassertion edge.

Configuration
REQ-025 SHALL use the macro NODE_REPORTER_CHECKSUM_EN.
REQ-026 SHALL, when NODE_REPORTER_CHECKSUM_EN is defined, send 4-byte frames with byte3 = byte0 ^ byte1 ^ byte2; when it is undefined, send 3-byte frames and instantiate no checksum logic.

Structure
REQ-027 SHALL place the header, side codes, class enum, FSM state typedef and frame-length constant in package node_reporter_pkg.
REQ-028 SHALL implement serialisation in sub-module uart_tx_byte (inputs start, data[7:0]; outputs tx, done; parameter CLK_DIV).

Verification (bench: CLK_DIV=4, DEBOUNCE=3)
REQ-029 SHALL cover: line_state 3'b110 held 3 cycles from 3'b010 -> node_count=1; frame A5 4C 01 E8 (E8 with checksum); start bit 2 cycles after the event; 40 cycles per byte.
REQ-030 SHALL cover: 3'b011 held only 2 cycles, then 3'b010 -> no event; xbee_tx stays 1; node_count=0.
REQ-031 SHALL cover: 3 events inside one frame -> frames for counts 1 and 2 sent back-to-back; count 3 dropped; node_count=3; overflow=1.
REQ-032 SHALL cover: node_count=255 followed by an R event -> node_count=0; frame A5 52 00 F7.
REQ-033 SHALL cover: rst_n low during byte1 -> xbee_tx=1 within the same cycle; all outputs at reset values; no further bits after release.
REQ-034 SHALL cover: checksum macro undefined, L event -> 3-byte frame A5 4C 01; busy low 1 cycle after stop bit of byte2.
